ctrl_sequencer: RTL
===================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control unit directly upstream of the datapath. Fetches 16-bit
//  instructions by PC and decodes each into the datapath control word CTRWRD,
//  constant Cin and memory-write strobe MW. Latches datapath flags V/C/N/Z for
//  conditional branches. Sequences execute cycles so the datapath's registered
//  busB/busD stages settle before the register-file write.
// PARAMETERS
//  RESET_PC  16'h0000  PC value on reset
//  CIN_SEXT  0         0: Cin = zero-ext Instr[3:0]; 1: sign-ext Instr[3:0]
// PORTS
//  CLK     in   1   clock, all state updates on posedge
//  RESET   in   1   asynchronous, active-high reset
//  Instr   in   16  instruction memory read data at address PC (combinational)
//  V,C,N,Z in   1   datapath flags, valid during EX1 of ALU instructions
//  CTRWRD  out  16  {DA[15:13],AA[12:10],BA[9:7],MB[6],FS[5:2],MD[1],RW[0]}
//  Cin     out  16  constant operand for datapath B-mux
//  PC      out  16  instruction address
//  MW      out  1   data memory write strobe (address=datapath Adrout, data=Dout)
//  Halted  out  1   high once HALT executed
// BEHAVIOUR
//  Reset: state=FETCH, PC=RESET_PC, IR=0, flags=0, Halted=0; outputs immediately
//   CTRWRD=0, Cin=0, MW=0. Reset mid-instruction aborts it; RW/MW drop same cycle.
//  Instruction fields: cls=[15:14], F=[13:10], DR=[9:7], SA=[6:4], SB=[3:1], imm=[3:0].
//   cls 00 ALU-reg: DA=DR AA=SA BA=SB MB=0 FS=F MD=0.
//   cls 01 ALU-imm: same but MB=1, Cin=ext(imm).
//   cls 10 mem: F[3]=0 LOAD R[DR]<-M[R[SA]] (MD=1, FS=0); F[3]=1 STORE
//    M[R[SA]]<-R[SB] (MB=0, MD=0).
//   cls 11 branch: F=cond, off=[9:0] sign-extended; F=1111 is HALT.
//    cond 0000 always, 0001 Z, 0010 N, 0011 C, 0100 V, 0101 !Z; 0110-1110 never.
//  CTRWRD/Cin/MW are combinational from registered state+IR only (no Instr path).
//   BA always Instr[3:1]; Cin=0 except cls 01.
//  States: FETCH, EX0, EX1, EX2, HALT.
//   FETCH: CTRWRD=0. Posedge: IR<=Instr, PC<=PC+1, ->EX0.
//   EX0: CTRWRD decoded, RW=0 (datapath captures busB2/busD2). Branch: if cond
//    true PC<=PC+sext(off) (PC already +1), ->FETCH; HALT ->HALT; else ->EX1.
//   EX1: same CTRWRD, RW=0. STORE: MW=1 this cycle only, ->FETCH. ALU: flags
//    latched at posedge from V/C/N/Z. ->EX2.
//   EX2: same CTRWRD with RW=1 (single write cycle), ->FETCH.
//   HALT: CTRWRD=0, MW=0, Halted=1, PC frozen; exit only by RESET.
//  Cycles/instr: ALU/LOAD 4, STORE 3, branch 2. Flags change only for cls 00/01.
//  PC arithmetic mod 2^16; wrap 16'hFFFF->16'h0000 silently, also on branch.
//  RW=1 only in EX2; MW=1 only in EX1 of STORE; never both.
// TESTING
//  1 Reset: RESET high during EX2 of ALU op -> same cycle CTRWRD=0, MW=0,
//    PC=RESET_PC; after release first FETCH at 16'h0000, no register write.
//  2 ALU-reg: Instr=16'h08A6 -> CTRWRD=16'h2988 in EX0/EX1, 16'h2989 in EX2,
//    Cin=0, next FETCH 4 cycles after previous FETCH.
//  3 ALU-imm: Instr=16'h489F -> Cin=16'h000F (CIN_SEXT=0) / 16'hFFFF
//    (CIN_SEXT=1), CTRWRD=16'h27C8 then 16'h27C9 in EX2.
//  4 Branch: Z latched 1, PC=16'h0010, Instr=16'hC7FC -> next FETCH PC=16'h000D;
//    with Z=0 -> PC=16'h0011; cond 0110 never taken.
//  5 Mem: STORE (cls 10, F[3]=1) -> MW high exactly 1 cycle (EX1), RW never 1;
//    LOAD -> MD=1 all EX cycles, RW=1 only EX2, MW=0; flags unchanged by both.
//  6 HALT: Instr=16'hFC00 -> Halted=1 after EX0, PC frozen, CTRWRD=0 for 20+
//    cycles; RESET pulse -> Halted=0, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/decode/execute control unit that sits
// directly upstream of the datapath. It fetches 16-bit instructions by PC and
// drives the datapath control word, the constant operand and the data-memory
// write strobe. Execution is stretched over several cycles so the datapath's
// registered busB/busD stages settle before the single register-file write.
module ctrl_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          CIN_SEXT = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] Instr,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [15:0] CTRWRD,
  output logic [15:0] Cin,
  output logic [15:0] PC,
  output logic        MW,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EX0   = 3'd1,
    S_EX1   = 3'd2,
    S_EX2   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] w_pc_next;
  logic [15:0] r_ir;
  logic        w_ir_load;
  logic [3:0]  r_flags;      // {V, C, N, Z}
  logic        w_flag_load;

  // Instruction fields, all taken from the registered IR so the outputs never
  // depend combinationally on the instruction-memory read data.
  logic [1:0]  w_cls;
  logic [3:0]  w_f;
  logic [2:0]  w_dr;
  logic [2:0]  w_sa;
  logic [2:0]  w_sb;
  logic [3:0]  w_imm;
  logic [15:0] w_off_sext;
  logic        w_is_alu;
  logic        w_is_imm;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_halt;
  logic        w_taken;
  logic [15:0] w_ctrl_word;  // decoded control word with RW cleared
  logic [15:0] w_cin_dec;

  assign w_cls       = r_ir[15:14];
  assign w_f         = r_ir[13:10];
  assign w_dr        = r_ir[9:7];
  assign w_sa        = r_ir[6:4];
  assign w_sb        = r_ir[3:1];
  assign w_imm       = r_ir[3:0];
  assign w_off_sext  = {{6{r_ir[9]}}, r_ir[9:0]};

  assign w_is_alu    = (w_cls[1] == 1'b0);
  assign w_is_imm    = (w_cls == 2'b01);
  assign w_is_load   = (w_cls == 2'b10) && !w_f[3];
  assign w_is_store  = (w_cls == 2'b10) &&  w_f[3];
  assign w_is_branch = (w_cls == 2'b11);
  assign w_is_halt   = w_is_branch && (w_f == 4'hF);

  // Memory ops run the ALU as a pass-through (FS=0); LOAD selects memory data
  // onto busD, STORE leaves MD=0 and relies on MW alone.
  assign w_ctrl_word = {w_dr, w_sa, w_sb, w_is_imm,
                        (w_is_alu ? w_f : 4'h0), w_is_load, 1'b0};

  assign w_cin_dec   = !w_is_imm ? 16'h0000 :
                       CIN_SEXT  ? {{12{w_imm[3]}}, w_imm} :
                                   {12'h000, w_imm};

  // Branch condition evaluated against the flags latched by the last ALU op.
  always_comb begin
    case (w_f)
      4'b0000: w_taken = 1'b1;
      4'b0001: w_taken = r_flags[0];
      4'b0010: w_taken = r_flags[1];
      4'b0011: w_taken = r_flags[2];
      4'b0100: w_taken = r_flags[3];
      4'b0101: w_taken = !r_flags[0];
      default: w_taken = 1'b0;
    endcase
  end

  // State, PC, IR and flag registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_flags <= 4'h0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_ir_load)   r_ir    <= Instr;
      if (w_flag_load) r_flags <= {V, C, N, Z};
    end
  end

  // Next-state, PC update and control outputs from registered state and IR.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ir_load    = 1'b0;
    w_flag_load  = 1'b0;
    CTRWRD       = 16'h0000;
    Cin          = 16'h0000;
    MW           = 1'b0;
    Halted       = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_ir_load    = 1'b1;
        w_pc_next    = r_pc + 16'd1;
        w_next_state = S_EX0;
      end
      S_EX0: begin
        CTRWRD = w_ctrl_word;
        Cin    = w_cin_dec;
        if (w_is_halt) begin
          w_next_state = S_HALT;
        end else if (w_is_branch) begin
          // PC already points past the branch; offset is relative to that.
          if (w_taken) w_pc_next = r_pc + w_off_sext;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_EX1;
        end
      end
      S_EX1: begin
        CTRWRD = w_ctrl_word;
        Cin    = w_cin_dec;
        if (w_is_store) begin
          MW           = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_flag_load  = w_is_alu;
          w_next_state = S_EX2;
        end
      end
      S_EX2: begin
        CTRWRD       = w_ctrl_word | 16'h0001;  // the one register-write cycle
        Cin          = w_cin_dec;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
  end

  assign PC = r_pc;

endmodule
